// File: rtl/led_meter_if.sv
// Front-panel meter bus: packed per-channel samples in, packed LED vector and
// update tick out.
interface led_meter_if #(
  parameter int CHANNELS  = 2,
  parameter int LED_BITS  = 16,
  parameter int DATA_BITS = 24
);
  logic [CHANNELS*DATA_BITS-1:0] data_in;
  logic                          data_valid;
  logic                          mode;
  logic                          peak_en;
  logic [CHANNELS*LED_BITS-1:0]  leds;
  logic                          tick;

  modport master (
    output data_in, data_valid, mode, peak_en,
    input  leds, tick
  );

  modport slave (
    input  data_in, data_valid, mode, peak_en,
    output leds, tick
  );
endinterface

// File: rtl/led_meter.sv
// Multi-channel LED level meter: windowed maximum per channel, quantised to a
// bar level, with a peak marker that holds for a number of windows then decays.
module led_meter #(
  parameter int CHANNELS    = 2,
  parameter int LED_BITS    = 16,
  parameter int DATA_BITS   = 24,
  parameter int TICK_PERIOD = 2**20,
  parameter int HOLD_TICKS  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  led_meter_if.slave bus
);
  localparam int CNT_W  = $clog2(TICK_PERIOD);
  localparam int LVL_W  = $clog2(LED_BITS + 1);
  localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int THR_W  = DATA_BITS + $clog2(LED_BITS) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_PERIOD - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_TICKS);

  // Threshold for LED idx; the extra width keeps full-scale * (idx+1) exact.
  function automatic logic [THR_W-1:0] thresh_f(input int idx);
    logic [THR_W-1:0] full_v;
    logic [THR_W-1:0] prod_v;
    full_v = (THR_W'(1) << DATA_BITS) - THR_W'(1);
    prod_v = full_v * THR_W'(idx + 1);
    return prod_v / THR_W'(LED_BITS);
  endfunction

  logic [CNT_W-1:0] cnt_r;
  logic             tick_r;
  logic             update_s;

  assign update_s = (cnt_r == CNT_LAST);
  assign bus.tick = tick_r;

  // Window counter and the tick marking the first cycle of fresh level/peak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= update_s ? '0 : cnt_r + CNT_W'(1);
      tick_r <= update_s;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DATA_BITS-1:0] sample_s;
    logic [DATA_BITS-1:0] max_r;
    logic [DATA_BITS-1:0] win_s;
    logic [LED_BITS-1:0]  ge_s;
    logic [LVL_W-1:0]     new_level_s;
    logic [LVL_W-1:0]     level_r;
    logic [LVL_W-1:0]     peak_r;
    logic [LVL_W-1:0]     peak_nxt_s;
    logic [HOLD_W-1:0]    hold_r;
    logic [HOLD_W-1:0]    hold_nxt_s;
    logic [LED_BITS-1:0]  pattern_s;
    logic [LED_BITS-1:0]  leds_r;

    assign sample_s = bus.data_in[c*DATA_BITS +: DATA_BITS];
    assign bus.leds[c*LED_BITS +: LED_BITS] = leds_r;

    // Running maximum including this cycle's sample when qualified.
    always_comb begin
      win_s = max_r;
      if (bus.data_valid && (sample_s > max_r)) begin
        win_s = sample_s;
      end else begin
        win_s = max_r;
      end
    end

    for (genvar i = 0; i < LED_BITS; i++) begin : g_thr
      localparam logic [THR_W-1:0] THR_V = thresh_f(i);
      assign ge_s[i] = ({{(THR_W-DATA_BITS){1'b0}}, win_s} >= THR_V);
    end

    // Level is the number of thresholds met by the window value.
    always_comb begin
      new_level_s = '0;
      for (int i = 0; i < LED_BITS; i++) begin
        new_level_s = new_level_s + LVL_W'(ge_s[i]);
      end
    end

    // Peak tracking: capture a new high, else count down hold, else decay.
    always_comb begin
      peak_nxt_s = peak_r;
      hold_nxt_s = hold_r;
      if (new_level_s >= peak_r) begin
        peak_nxt_s = new_level_s;
        hold_nxt_s = HOLD_INIT;
      end else if (hold_r != '0) begin
        hold_nxt_s = hold_r - HOLD_W'(1);
      end else if (peak_r != '0) begin
        peak_nxt_s = peak_r - LVL_W'(1);
      end else begin
        peak_nxt_s = peak_r;
        hold_nxt_s = hold_r;
      end
    end

    // Max, level, peak and hold; the max restarts at every window boundary.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        max_r   <= '0;
        level_r <= '0;
        peak_r  <= '0;
        hold_r  <= '0;
      end else if (update_s) begin
        max_r   <= '0;
        level_r <= new_level_s;
        peak_r  <= peak_nxt_s;
        hold_r  <= hold_nxt_s;
      end else begin
        max_r   <= win_s;
      end
    end

    // Bar or dot pattern with the optional peak marker ORed on top.
    always_comb begin
      pattern_s = '0;
      for (int i = 0; i < LED_BITS; i++) begin
        pattern_s[i] = (bus.mode ? ((level_r != '0) && (LVL_W'(i) == level_r - LVL_W'(1)))
                                 : (LVL_W'(i) < level_r))
                     | (bus.peak_en && (peak_r != '0) && (LVL_W'(i) == peak_r - LVL_W'(1)));
      end
    end

    // Registered LED drive so the board sees no combinational glitches.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        leds_r <= '0;
      end else begin
        leds_r <= pattern_s;
      end
    end
  end
endmodule

// File: tb/tb_led_meter.sv
// Self-checking bench for led_meter: randomized samples compared per cycle
// against a window-level reference model, plus fixed scenario checks.
module tb_led_meter;
  localparam int CH = 2, LB = 4, DB = 8, TP = 8, HT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  led_meter_if #(.CHANNELS(CH), .LED_BITS(LB), .DATA_BITS(DB)) bus ();

  led_meter #(
    .CHANNELS(CH), .LED_BITS(LB), .DATA_BITS(DB), .TICK_PERIOD(TP), .HOLD_TICKS(HT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int m_cnt;
  int m_max   [CH];
  int m_level [CH];
  int m_peak  [CH];
  int m_hold  [CH];
  logic [CH*LB-1:0] m_leds;
  logic             m_tick;

  // level = #{i : v >= floor(F*(i+1)/LB)}  ==  floor((LB*(v+1)-1)/F), capped at LB
  function automatic int level_of(input int v);
    int l;
    l = (LB * (v + 1) - 1) / ((1 << DB) - 1);
    if (l > LB) l = LB;
    return l;
  endfunction

  function automatic logic [LB-1:0] pattern_of(input int level, input int peak,
                                               input logic md, input logic pe);
    logic [LB-1:0] p;
    if (md) p = (level > 0) ? (LB'(1) << (level - 1)) : '0;
    else    p = LB'((1 << level) - 1);
    if (pe && peak > 0) p = p | (LB'(1) << (peak - 1));
    return p;
  endfunction

  task automatic model_clear();
    m_cnt = 0;
    for (int c = 0; c < CH; c++) begin
      m_max[c] = 0; m_level[c] = 0; m_peak[c] = 0; m_hold[c] = 0;
    end
    m_leds = '0;
    m_tick = 1'b0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then settle.
  task automatic clk_cycle();
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      for (int c = 0; c < CH; c++)
        m_leds[c*LB +: LB] = pattern_of(m_level[c], m_peak[c], bus.mode, bus.peak_en);
      m_tick = (m_cnt == TP - 1);
      for (int c = 0; c < CH; c++) begin
        int s, w, lv;
        s = bus.data_valid ? int'(bus.data_in[c*DB +: DB]) : 0;
        w = (s > m_max[c]) ? s : m_max[c];
        if (m_cnt == TP - 1) begin
          lv = level_of(w);
          if (lv >= m_peak[c]) begin
            m_peak[c] = lv;
            m_hold[c] = HT;
          end else if (m_hold[c] != 0) begin
            m_hold[c] = m_hold[c] - 1;
          end else if (m_peak[c] > 0) begin
            m_peak[c] = m_peak[c] - 1;
          end
          m_level[c] = lv;
          m_max[c]   = 0;
        end else begin
          m_max[c] = w;
        end
      end
      m_cnt = (m_cnt + 1) % TP;
    end
    #1;
  endtask

  task automatic drive(input int s0, input int s1, input logic v);
    bus.data_in    = {DB'(s1), DB'(s0)};
    bus.data_valid = v;
    clk_cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) clk_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clk_cycle();
    total_cnt++;
    if (bus.leds !== '0 || bus.tick !== 1'b0)
      $display("FAIL reset_values: leds=%b tick=%b, expected leds=0 tick=0", bus.leds, bus.tick);
    else pass_cnt++;
    do_reset();
    for (int k = 0; k < TP + 2; k++) begin
      drive($urandom_range(0, 255), $urandom_range(0, 255), 1'b1);
      total_cnt++;
      if (bus.leds !== m_leds || bus.tick !== m_tick)
        $display("FAIL reset_release k%0d: leds=%b tick=%b, expected leds=%b tick=%b",
                 k, bus.leds, bus.tick, m_leds, m_tick);
      else pass_cnt++;
    end
  endtask

  task automatic test_threshold();
    do_reset();
    bus.mode = 1'b0; bus.peak_en = 1'b0;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < TP; k++) begin
        drive((w == 0) ? 62 : ((w == 1) ? 63 : int'($urandom_range(0, 255))), 255, 1'b1);
        total_cnt++;
        if (bus.leds !== m_leds || bus.tick !== m_tick)
          $display("FAIL thr_cycle w%0d k%0d: leds=%b tick=%b, expected leds=%b tick=%b",
                   w, k, bus.leds, bus.tick, m_leds, m_tick);
        else pass_cnt++;
        if (k == 0 && w == 1) begin
          total_cnt++;
          if (bus.leds !== 8'b1111_0000)
            $display("FAIL thr_62: leds=%b, expected 11110000", bus.leds);
          else pass_cnt++;
        end
        if (k == 0 && w == 2) begin
          total_cnt++;
          if (bus.leds[3:0] !== 4'b0001)
            $display("FAIL thr_63: ch0=%b, expected 0001", bus.leds[3:0]);
          else pass_cnt++;
        end
      end
    end
  endtask

  task automatic test_running_max();
    logic [3:0] lit [3];
    int s0;
    logic v;
    lit = '{4'b0111, 4'b0000, 4'b1111};
    do_reset();
    bus.mode = 1'b0; bus.peak_en = 1'b0;
    for (int w = 0; w < 7; w++) begin
      for (int k = 0; k < TP; k++) begin
        v = 1'b1;
        case (w)
          0: s0 = (k == 3) ? 200 : 0;
          1: begin s0 = (k == 2) ? 255 : 10; v = (k != 2); end
          2: s0 = (k == TP - 1) ? 255 : 5;
          default: begin s0 = $urandom_range(0, 255); v = 1'($urandom_range(0, 1)); end
        endcase
        drive(s0, $urandom_range(0, 255), v);
        total_cnt++;
        if (bus.leds !== m_leds || bus.tick !== m_tick)
          $display("FAIL max_cycle w%0d k%0d: leds=%b tick=%b, expected leds=%b tick=%b",
                   w, k, bus.leds, bus.tick, m_leds, m_tick);
        else pass_cnt++;
        if (k == 0 && w >= 1 && w <= 3) begin
          total_cnt++;
          if (bus.leds[3:0] !== lit[w-1])
            $display("FAIL max_window%0d: ch0=%b, expected %b", w - 1, bus.leds[3:0], lit[w-1]);
          else pass_cnt++;
        end
      end
    end
  endtask

  task automatic test_peak_decay();
    logic [3:0] tab [6];
    tab = '{4'b0111, 4'b0100, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
    do_reset();
    bus.mode = 1'b0; bus.peak_en = 1'b1;
    for (int w = 0; w < 7; w++) begin
      for (int k = 0; k < TP; k++) begin
        drive((w == 0 && k == 4) ? 200 : 0, $urandom_range(0, 255), 1'b1);
        total_cnt++;
        if (bus.leds !== m_leds || bus.tick !== m_tick)
          $display("FAIL peak_cycle w%0d k%0d: leds=%b tick=%b, expected leds=%b tick=%b",
                   w, k, bus.leds, bus.tick, m_leds, m_tick);
        else pass_cnt++;
        if (k == 0 && w >= 1) begin
          total_cnt++;
          if (bus.leds[3:0] !== tab[w-1])
            $display("FAIL peak_W%0d: ch0=%b, expected %b", w, bus.leds[3:0], tab[w-1]);
          else pass_cnt++;
        end
      end
    end
  endtask

  task automatic test_dot_mode();
    do_reset();
    bus.mode = 1'b1; bus.peak_en = 1'b0;
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < TP; k++) begin
        if (w == 1 && k == 3) bus.mode = 1'b0;
        drive(130, $urandom_range(0, 255), 1'b1);
        total_cnt++;
        if (bus.leds !== m_leds || bus.tick !== m_tick)
          $display("FAIL dot_cycle w%0d k%0d: leds=%b tick=%b, expected leds=%b tick=%b",
                   w, k, bus.leds, bus.tick, m_leds, m_tick);
        else pass_cnt++;
        if (w == 1 && (k == 0 || k == 3)) begin
          total_cnt++;
          if (bus.leds[3:0] !== ((k == 0) ? 4'b0010 : 4'b0011))
            $display("FAIL dot_k%0d: ch0=%b, expected %b", k, bus.leds[3:0],
                     (k == 0) ? 4'b0010 : 4'b0011);
          else pass_cnt++;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    bus.mode = 1'b0; bus.peak_en = 1'b1;
    for (int k = 0; k < TP + 4; k++) drive((k < TP) ? 255 : 0, (k < TP) ? 200 : 0, 1'b1);
    total_cnt++;
    if (bus.leds !== m_leds)
      $display("FAIL rstmid_before: leds=%b, expected %b", bus.leds, m_leds);
    else pass_cnt++;
    rst_n = 1'b0;
    model_clear();
    #1;
    total_cnt++;
    if (bus.leds !== '0 || bus.tick !== 1'b0)
      $display("FAIL rstmid_async: leds=%b tick=%b, expected leds=0 tick=0", bus.leds, bus.tick);
    else pass_cnt++;
    clk_cycle();
    clk_cycle();
    rst_n = 1'b1;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 1'b0);
      total_cnt++;
      if (bus.leds !== m_leds || bus.tick !== m_tick)
        $display("FAIL rstmid_cycle k%0d: leds=%b tick=%b, expected leds=%b tick=%b",
                 k, bus.leds, bus.tick, m_leds, m_tick);
      else pass_cnt++;
      if (bus.tick === 1'b1) begin
        n = k;
        break;
      end
    end
    total_cnt++;
    if (n !== TP)
      $display("FAIL rstmid_first_tick: tick after %0d cycles, expected %0d", n, TP);
    else pass_cnt++;
  endtask

  task automatic test_tick_timing();
    logic [CH*LB-1:0] prev_leds;
    logic             prev_tick;
    int               ticks;
    do_reset();
    bus.mode = 1'($urandom_range(0, 1)); bus.peak_en = 1'b1;
    prev_leds = bus.leds; prev_tick = bus.tick; ticks = 0;
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < TP; k++) begin
        drive($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
        total_cnt++;
        if (bus.leds !== m_leds || bus.tick !== (k == TP - 1))
          $display("FAIL tick_cycle w%0d k%0d: leds=%b tick=%b, expected leds=%b tick=%b",
                   w, k, bus.leds, bus.tick, m_leds, (k == TP - 1));
        else pass_cnt++;
        total_cnt++;
        if (bus.leds !== prev_leds && prev_tick !== 1'b1)
          $display("FAIL tick_led_align w%0d k%0d: leds changed %b->%b, expected no change",
                   w, k, prev_leds, bus.leds);
        else pass_cnt++;
        if (bus.tick === 1'b1) ticks++;
        prev_leds = bus.leds;
        prev_tick = bus.tick;
      end
    end
    total_cnt++;
    if (ticks !== 5)
      $display("FAIL tick_count: %0d ticks, expected 5", ticks);
    else pass_cnt++;
  endtask

  initial begin
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    bus.mode       = 1'b0;
    bus.peak_en    = 1'b0;
    model_clear();
    test_reset();
    test_threshold();
    test_running_max();
    test_peak_decay();
    test_dot_mode();
    test_reset_mid();
    test_tick_timing();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
